// File: rtl/hazard_sched_pkg.sv
// Shared encodings for the decode-stage hazard scheduler: FSM states,
// instruction field positions, default load opcode and NOP encoding.
package hazard_sched_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    localparam int OP_MSB   = 31;
    localparam int OP_LSB   = 26;
    localparam int DST_MSB  = 25;
    localparam int DST_LSB  = 21;
    localparam int SRCA_MSB = 20;
    localparam int SRCA_LSB = 16;
    localparam int SRCB_MSB = 15;
    localparam int SRCB_LSB = 11;

    localparam logic [5:0]  LOAD_OP_DEF = 6'b010100;
    localparam logic [31:0] NOP_INS     = 32'h0000_0000;

    localparam int CNT_W = 3;

    // Immediate-form ops (op[3]=1) and loads carry no register in the srcB field.
    function automatic logic srcb_used(input logic [5:0] op, input logic [5:0] load_op);
        return (op[3] == 1'b0) && (op != load_op);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard check between the decode slot and the
// instruction currently in EX.
module hazard_detect
    import hazard_sched_pkg::*;
#(
    parameter logic [5:0] LOAD_OP = LOAD_OP_DEF
) (
    input  logic [31:0] ins,
    input  logic        ins_valid,
    input  logic        ex_valid,
    input  logic        ex_load,
    input  logic [4:0]  ex_dst,
    output logic        hz
);

    logic [5:0] op;
    logic [4:0] src_a;
    logic [4:0] src_b;
    logic       hit_a;
    logic       hit_b;
    logic       unused_lo;

    assign op        = ins[OP_MSB:OP_LSB];
    assign src_a     = ins[SRCA_MSB:SRCA_LSB];
    assign src_b     = ins[SRCB_MSB:SRCB_LSB];
    assign unused_lo = ^{ins[DST_MSB:DST_LSB], ins[SRCB_LSB-1:0]};

    assign hit_a = (ex_dst == src_a);
    assign hit_b = srcb_used(op, LOAD_OP) && (ex_dst == src_b);

    // r0 is hardwired zero, so a load targeting it never blocks a consumer.
    assign hz = ins_valid && ex_valid && ex_load && (ex_dst != 5'd0) && (hit_a || hit_b);

endmodule

// File: rtl/hazard_sched.sv
// Decode-stage hazard scheduler: load-use stalls, taken-branch flushes and
// memory holds. Optional perf counters under HAZARD_PERF_CNT_EN.
module hazard_sched
    import hazard_sched_pkg::*;
#(
    parameter logic [5:0] LOAD_OP    = LOAD_OP_DEF,
    parameter int         LOAD_STALL = 1,
    parameter int         FLUSH_CYC  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ins,
    input  logic        ins_valid,
    input  logic        br_taken,
    input  logic        mem_hold,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic [1:0]  state
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_cycles
`endif
);

    localparam logic [CNT_W-1:0] STALL_INIT = (LOAD_STALL > 1) ? CNT_W'(LOAD_STALL - 2) : '0;
    localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'(FLUSH_CYC - 1);

    state_e           state_q, state_d;
    state_e           sav_q, sav_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ex_valid_q, ex_valid_d;
    logic             ex_load_q, ex_load_d;
    logic [4:0]       ex_dst_q, ex_dst_d;

    logic hz;
    logic frz;
    logic pc_en_c, ifid_en_c, flush_c, bubble_c, stall_act;

    hazard_detect #(.LOAD_OP(LOAD_OP)) u_detect (
        .ins       (ins),
        .ins_valid (ins_valid),
        .ex_valid  (ex_valid_q),
        .ex_load   (ex_load_q),
        .ex_dst    (ex_dst_q),
        .hz        (hz)
    );

    // The cycle mem_hold drops is still spent in HOLD; the front end resumes next edge.
    assign frz = mem_hold || (state_q == ST_HOLD);

    always_comb begin
        state_d   = state_q;
        sav_d     = sav_q;
        cnt_d     = cnt_q;
        pc_en_c   = 1'b1;
        ifid_en_c = 1'b1;
        flush_c   = 1'b0;
        bubble_c  = 1'b0;
        stall_act = 1'b0;
        if (frz) begin
            pc_en_c   = 1'b0;
            ifid_en_c = 1'b0;
            if (state_q != ST_HOLD) sav_d = state_q;
            state_d = mem_hold ? ST_HOLD : sav_q;
        end else if (br_taken) begin
            flush_c  = 1'b1;
            bubble_c = 1'b1;
            state_d  = (FLUSH_CYC > 1) ? ST_FLUSH : ST_RUN;
            cnt_d    = (FLUSH_CYC > 1) ? FLUSH_INIT : '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (hz) begin
                        pc_en_c   = 1'b0;
                        ifid_en_c = 1'b0;
                        bubble_c  = 1'b1;
                        stall_act = 1'b1;
                        if (LOAD_STALL > 1) begin
                            state_d = ST_STALL;
                            cnt_d   = STALL_INIT;
                        end
                    end
                end
                ST_STALL: begin
                    pc_en_c   = 1'b0;
                    ifid_en_c = 1'b0;
                    bubble_c  = 1'b1;
                    stall_act = 1'b1;
                    if (cnt_q == '0) state_d = ST_RUN;
                    else             cnt_d   = cnt_q - 1'b1;
                end
                ST_FLUSH: begin
                    flush_c  = 1'b1;
                    bubble_c = 1'b1;
                    // cnt holds the FLUSH cycles still owed, including this one.
                    if (cnt_q <= 1) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_load_d  = ex_load_q;
        ex_dst_d   = ex_dst_q;
        if (!frz) begin
            if (!bubble_c && ins_valid) begin
                ex_valid_d = 1'b1;
                ex_load_d  = (ins[OP_MSB:OP_LSB] == LOAD_OP);
                ex_dst_d   = ins[DST_MSB:DST_LSB];
            end else begin
                ex_valid_d = 1'b0;
                ex_load_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_RUN;
            sav_q      <= ST_RUN;
            cnt_q      <= '0;
            ex_valid_q <= 1'b0;
            ex_load_q  <= 1'b0;
            ex_dst_q   <= 5'd0;
        end else begin
            state_q    <= state_d;
            sav_q      <= sav_d;
            cnt_q      <= cnt_d;
            ex_valid_q <= ex_valid_d;
            ex_load_q  <= ex_load_d;
            ex_dst_q   <= ex_dst_d;
        end
    end

    assign pc_en       = reset & pc_en_c;
    assign ifid_en     = reset & ifid_en_c;
    assign ifid_flush  = ~reset | flush_c;
    assign idex_bubble = ~reset | bubble_c;
    assign state       = state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_act && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
        if (flush_c   && flush_cnt_q != 16'hFFFF) flush_cnt_d = flush_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_cycles = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_sched.sv
// Scoreboard bench for hazard_sched (LOAD_STALL=1, FLUSH_CYC=2).
module tb_hazard_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] ins = '0;
    logic        ins_valid = 1'b0;
    logic        br_taken = 1'b0;
    logic        mem_hold = 1'b0;
    logic        pc_en, ifid_en, ifid_flush, idex_bubble;
    logic [1:0]  state;
`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cycles, flush_cycles;
`endif

    hazard_sched #(.LOAD_STALL(1), .FLUSH_CYC(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .ins         (ins),
        .ins_valid   (ins_valid),
        .br_taken    (br_taken),
        .mem_hold    (mem_hold),
        .pc_en       (pc_en),
        .ifid_en     (ifid_en),
        .ifid_flush  (ifid_flush),
        .idex_bubble (idex_bubble),
        .state       (state)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles(stall_cycles),
        .flush_cycles(flush_cycles)
`endif
    );

    always #5 clk = ~clk;

    // Expected vector layout: {pc_en, ifid_en, ifid_flush, idex_bubble, state[1:0]}
    localparam logic [5:0] E_RUN = 6'b110000;
    localparam logic [5:0] E_HZ  = 6'b000100;
    localparam logic [5:0] E_BR  = 6'b111100;
    localparam logic [5:0] E_FL  = 6'b111110;
    localparam logic [5:0] E_HR  = 6'b000000;
    localparam logic [5:0] E_HF  = 6'b000010;
    localparam logic [5:0] E_HH  = 6'b000011;
    localparam logic [5:0] E_RST = 6'b001100;

    localparam logic [31:0] LD_R4  = {6'b010100, 5'd4, 5'd1, 16'h0000};
    localparam logic [31:0] ADD_B4 = {6'b000100, 5'd5, 5'd1, 5'd4, 11'h0};
    localparam logic [31:0] ADD_A4 = {6'b000100, 5'd5, 5'd4, 5'd2, 11'h0};
    localparam logic [31:0] IMM_B4 = {6'b001101, 5'd6, 5'd1, 5'd4, 11'h0};
    localparam logic [31:0] LD_R0  = {6'b010100, 5'd0, 5'd1, 16'h0000};
    localparam logic [31:0] USE_R0 = {6'b000100, 5'd5, 5'd0, 5'd0, 11'h0};
    localparam logic [31:0] LD_B4  = {6'b010100, 5'd7, 5'd1, 5'd4, 11'h0};

    typedef struct {
        logic [31:0] i;
        logic        v;
        logic        b;
        logic        h;
        logic [5:0]  e;
    } vec_t;

    int         total = 0;
    int         bad = 0;
    logic [5:0] exp_q[$];

    function automatic vec_t V(input logic [31:0] i, input logic v, input logic b,
                               input logic h, input logic [5:0] e);
        vec_t r;
        r.i = i; r.v = v; r.b = b; r.h = h; r.e = e;
        return r;
    endfunction

    function automatic logic [5:0] obs();
        return {pc_en, ifid_en, ifid_flush, idex_bubble, state};
    endfunction

    // Drive one cycle of stimulus (from posedge+1) and queue its expectation.
    task automatic drive(input vec_t t);
        ins = t.i; ins_valid = t.v; br_taken = t.b; mem_hold = t.h;
        exp_q.push_back(t.e);
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [5:0] want;
        exp_q.push_back(E_RST);
        #2;
        want = exp_q.pop_front(); total++;
        if (obs() !== want) begin bad++; $display("FAIL reset_async got=%b want=%b", obs(), want); end
        @(posedge clk); #1;
        exp_q.push_back(E_RST);
        want = exp_q.pop_front(); total++;
        if (obs() !== want) begin bad++; $display("FAIL reset_edge got=%b want=%b", obs(), want); end
        reset = 1'b1;
        drive(V(32'h0, 1'b0, 1'b0, 1'b0, E_RUN));
        want = exp_q.pop_front(); total++;
        if (obs() !== want) begin bad++; $display("FAIL reset_release got=%b want=%b", obs(), want); end
        @(posedge clk); #1;
    endtask

    task automatic test_load_use();
        vec_t tv[$];
        logic [5:0] want;
`ifdef HAZARD_PERF_CNT_EN
        logic [15:0] s0 = stall_cycles;
`endif
        tv.push_back(V(LD_R4,  1'b1, 1'b0, 1'b0, E_RUN));
        tv.push_back(V(ADD_B4, 1'b1, 1'b0, 1'b0, E_HZ));
        tv.push_back(V(ADD_B4, 1'b1, 1'b0, 1'b0, E_RUN));
        tv.push_back(V(LD_R4,  1'b1, 1'b0, 1'b0, E_RUN));
        tv.push_back(V(ADD_A4, 1'b1, 1'b0, 1'b0, E_HZ));
        tv.push_back(V(ADD_A4, 1'b1, 1'b0, 1'b0, E_RUN));
        tv.push_back(V(32'h0,  1'b0, 1'b0, 1'b0, E_RUN));
        foreach (tv[k]) begin
            drive(tv[k]);
            want = exp_q.pop_front(); total++;
            if (obs() !== want) begin bad++; $display("FAIL load_use[%0d] got=%b want=%b", k, obs(), want); end
            @(posedge clk); #1;
        end
`ifdef HAZARD_PERF_CNT_EN
        total++;
        if (stall_cycles - s0 !== 16'd2) begin
            bad++; $display("FAIL load_use_perf got=%0d want=2", stall_cycles - s0);
        end
`endif
    endtask

    task automatic test_no_false();
        vec_t tv[$];
        logic [5:0] want;
        tv.push_back(V(LD_R4,  1'b1, 1'b0, 1'b0, E_RUN));
        tv.push_back(V(IMM_B4, 1'b1, 1'b0, 1'b0, E_RUN));
        tv.push_back(V(LD_R0,  1'b1, 1'b0, 1'b0, E_RUN));
        tv.push_back(V(USE_R0, 1'b1, 1'b0, 1'b0, E_RUN));
        tv.push_back(V(LD_R4,  1'b1, 1'b0, 1'b0, E_RUN));
        tv.push_back(V(LD_B4,  1'b1, 1'b0, 1'b0, E_RUN));
        tv.push_back(V(LD_R4,  1'b1, 1'b0, 1'b0, E_RUN));
        tv.push_back(V(ADD_B4, 1'b0, 1'b0, 1'b0, E_RUN));
        tv.push_back(V(ADD_B4, 1'b1, 1'b0, 1'b0, E_RUN));
        tv.push_back(V(32'h0,  1'b0, 1'b0, 1'b0, E_RUN));
        foreach (tv[k]) begin
            drive(tv[k]);
            want = exp_q.pop_front(); total++;
            if (obs() !== want) begin bad++; $display("FAIL no_false[%0d] got=%b want=%b", k, obs(), want); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        vec_t tv[$];
        logic [5:0] want;
`ifdef HAZARD_PERF_CNT_EN
        logic [15:0] f0 = flush_cycles;
`endif
        tv.push_back(V(32'h0, 1'b0, 1'b1, 1'b0, E_BR));
        tv.push_back(V(32'h0, 1'b0, 1'b0, 1'b0, E_FL));
        tv.push_back(V(32'h0, 1'b0, 1'b0, 1'b0, E_RUN));
        foreach (tv[k]) begin
            drive(tv[k]);
            want = exp_q.pop_front(); total++;
            if (obs() !== want) begin bad++; $display("FAIL branch[%0d] got=%b want=%b", k, obs(), want); end
            @(posedge clk); #1;
        end
`ifdef HAZARD_PERF_CNT_EN
        total++;
        if (flush_cycles - f0 !== 16'd2) begin
            bad++; $display("FAIL branch_perf got=%0d want=2", flush_cycles - f0);
        end
`endif
    endtask

    task automatic test_hold_flush();
        vec_t tv[$];
        logic [5:0] want;
        tv.push_back(V(32'h0, 1'b0, 1'b1, 1'b0, E_BR));
        tv.push_back(V(32'h0, 1'b0, 1'b0, 1'b1, E_HF));
        tv.push_back(V(32'h0, 1'b0, 1'b0, 1'b1, E_HH));
        tv.push_back(V(32'h0, 1'b0, 1'b0, 1'b1, E_HH));
        tv.push_back(V(32'h0, 1'b0, 1'b0, 1'b0, E_HH));
        tv.push_back(V(32'h0, 1'b0, 1'b0, 1'b0, E_FL));
        tv.push_back(V(32'h0, 1'b0, 1'b0, 1'b0, E_RUN));
        foreach (tv[k]) begin
            drive(tv[k]);
            want = exp_q.pop_front(); total++;
            if (obs() !== want) begin bad++; $display("FAIL hold_flush[%0d] got=%b want=%b", k, obs(), want); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_hold_ex();
        vec_t tv[$];
        logic [5:0] want;
        tv.push_back(V(LD_R4,  1'b1, 1'b0, 1'b0, E_RUN));
        tv.push_back(V(ADD_B4, 1'b1, 1'b0, 1'b1, E_HR));
        tv.push_back(V(ADD_B4, 1'b1, 1'b0, 1'b1, E_HH));
        tv.push_back(V(ADD_B4, 1'b1, 1'b0, 1'b0, E_HH));
        tv.push_back(V(ADD_B4, 1'b1, 1'b0, 1'b0, E_HZ));
        tv.push_back(V(ADD_B4, 1'b1, 1'b0, 1'b0, E_RUN));
        foreach (tv[k]) begin
            drive(tv[k]);
            want = exp_q.pop_front(); total++;
            if (obs() !== want) begin bad++; $display("FAIL hold_ex[%0d] got=%b want=%b", k, obs(), want); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_simul();
        vec_t tv[$];
        logic [5:0] want;
`ifdef HAZARD_PERF_CNT_EN
        logic [15:0] s0 = stall_cycles;
`endif
        tv.push_back(V(LD_R4,  1'b1, 1'b0, 1'b0, E_RUN));
        tv.push_back(V(ADD_B4, 1'b1, 1'b1, 1'b0, E_BR));
        tv.push_back(V(ADD_B4, 1'b1, 1'b0, 1'b0, E_FL));
        tv.push_back(V(ADD_B4, 1'b1, 1'b0, 1'b0, E_RUN));
        tv.push_back(V(32'h0,  1'b0, 1'b0, 1'b0, E_RUN));
        foreach (tv[k]) begin
            drive(tv[k]);
            want = exp_q.pop_front(); total++;
            if (obs() !== want) begin bad++; $display("FAIL simul[%0d] got=%b want=%b", k, obs(), want); end
            @(posedge clk); #1;
        end
`ifdef HAZARD_PERF_CNT_EN
        total++;
        if (stall_cycles !== s0) begin
            bad++; $display("FAIL simul_perf got=%0d want=%0d", stall_cycles, s0);
        end
`endif
    endtask

    task automatic test_back_to_back();
        vec_t tv[$];
        logic [5:0] want;
        tv.push_back(V(32'h0, 1'b0, 1'b1, 1'b0, E_BR));
        tv.push_back(V(32'h0, 1'b0, 1'b1, 1'b0, E_FL));
        tv.push_back(V(32'h0, 1'b0, 1'b0, 1'b0, E_FL));
        tv.push_back(V(32'h0, 1'b0, 1'b0, 1'b0, E_RUN));
        foreach (tv[k]) begin
            drive(tv[k]);
            want = exp_q.pop_front(); total++;
            if (obs() !== want) begin bad++; $display("FAIL back_to_back[%0d] got=%b want=%b", k, obs(), want); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_async_reset();
        logic [5:0] want;
        drive(V(32'h0, 1'b0, 1'b1, 1'b0, E_BR));
        want = exp_q.pop_front(); total++;
        if (obs() !== want) begin bad++; $display("FAIL areset_br got=%b want=%b", obs(), want); end
        @(posedge clk); #1;
        br_taken = 1'b0;
        reset = 1'b0;
        exp_q.push_back(E_RST);
        #1;
        want = exp_q.pop_front(); total++;
        if (obs() !== want) begin bad++; $display("FAIL areset_mid got=%b want=%b", obs(), want); end
        @(posedge clk); #1;
        reset = 1'b1;
        drive(V(32'h0, 1'b0, 1'b0, 1'b0, E_RUN));
        want = exp_q.pop_front(); total++;
        if (obs() !== want) begin bad++; $display("FAIL areset_after got=%b want=%b", obs(), want); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_false();
        test_branch();
        test_hold_flush();
        test_hold_ex();
        test_simul();
        test_back_to_back();
        test_async_reset();
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
